enemy_life: RTL
===============

# enemy_life

Per-enemy life-cycle controller, one instance per `enemy` instance, directly upstream of it. Turns single-cycle bullet-hit events into the `Enemy_Is_Attacked` and `is_alive` levels that `enemy` consumes. Tracks hit points, invulnerability after a hit, the death hold and the respawn delay. Emits kill and respawn pulses for the score logic and for the top-level position reset.

## Interface
- `ID`, 0: enemy index; staggers the initial spawn delay.
- `MAX_HP`, 4: hit points on spawn, 1..15.
- `HIT_FRAMES`, 7: frames of invulnerability after a hit. Matches the stay/back-off window in `enemy`.
- `DEATH_FRAMES`, 16: frames spent in DYING.
- `RESPAWN_FRAMES`, 120: frames spent in DEAD before respawn.
- `SPAWN_FRAMES`, 30: base initial delay; the first spawn delay is `SPAWN_FRAMES*(ID+1)`.
- `Clk` in 1: 50 MHz system clock.
- `Reset_n` in 1: asynchronous, active-low reset.
- `game_frame_clk_rising_edge` in 1: one-`Clk` pulse per game frame.
- `Game_Enable` in 1: when low, the FSM state and all counters hold.
- `Bullet_Hit` in 1: one-`Clk` pulse from the bullet/enemy collision logic.
- `Bullet_Damage` in 4: HP removed per hit, sampled with `Bullet_Hit`.
- `is_alive` out 1: high in ALIVE and HURT.
- `Enemy_Is_Attacked` out 1: hit level presented to `enemy`.
- `Enemy_HP` out 4: current hit points.
- `Dying` out 1: high in DYING; selects the death sprite.
- `Kill_Pulse` out 1: one `Clk` when HP reaches 0.
- `Respawn_Pulse` out 1: one `Clk` on the DEAD→ALIVE transition.

## Operation
- States: SPAWN_WAIT, ALIVE, HURT, DYING, DEAD. One shared 8-bit frame counter, `frame_cnt`.
- **Reset (async):** state = SPAWN_WAIT, `frame_cnt` = 0, `Enemy_HP` = 0, all outputs low.
- **SPAWN_WAIT:**
  - Increments `frame_cnt` on each frame tick.
  - When `frame_cnt` reaches `SPAWN_FRAMES*(ID+1)-1` on a tick: go to ALIVE, HP = `MAX_HP`, pulse `Respawn_Pulse`, clear `frame_cnt`.
- **ALIVE:**
  - `Bullet_Hit` sets new HP = HP − `Bullet_Damage`, saturating at 0. Subtraction is done 5 bits wide and clamped.
  - If the new HP is 0: go to DYING, pulse `Kill_Pulse`.
  - Otherwise: go to HURT and set `Enemy_Is_Attacked`.
  - `Enemy_Is_Attacked` stays high until the first frame tick after entry has been seen, then clears. `enemy` therefore samples it on exactly one tick.
- **HURT:**
  - Counts frame ticks. After `HIT_FRAMES` ticks, return to ALIVE.
  - `Bullet_Hit` in HURT is ignored (invulnerable).
- **DYING:**
  - `is_alive` = 0, `Dying` = 1.
  - After `DEATH_FRAMES` ticks, go to DEAD.
- **DEAD:**
  - All outputs low; `Enemy_HP` = 0.
  - After `RESPAWN_FRAMES` ticks: go to ALIVE, HP = `MAX_HP`, pulse `Respawn_Pulse`.
- `Bullet_Hit` outside ALIVE: no effect.
- `Bullet_Damage` = 0 in ALIVE: still a hit. HP unchanged, goes to HURT, `Enemy_Is_Attacked` pulses.
- `Game_Enable` low: hits are dropped, ticks are not counted, and any pending `Enemy_Is_Attacked` is held.

## Timing
- All outputs are registered.
- Hit at cycle N: state, HP and `Enemy_Is_Attacked` update at N+1. `Kill_Pulse` is high during N+1 only.
- `Enemy_Is_Attacked` falls in the cycle after the first tick that occurs at or after N+1.
- Hit coincident with a tick (same cycle N): the hit is taken. That tick does not count toward `HIT_FRAMES`; `Enemy_Is_Attacked` is held through the next tick.
- Kill: `is_alive` falls at N+1, in the same cycle as `Kill_Pulse`.
- Frame counts are exact: state exits on the cycle after the Kth tick since entry, where K is the relevant parameter.
- `Respawn_Pulse` and the rise of `is_alive` occur in the same cycle.
- `Reset_n` low at any point forces the reset state immediately. Deassertion is synchronised externally.

## Structure
- `enemy_life_pkg`: `life_state_t` enum, `HP_W` = 4, and the frame-count width constant.
- One sub-module, `frame_timer`: loadable frame-tick down-counter with a `done` flag. It is shared by SPAWN_WAIT, HURT, DYING and DEAD.
- FSM and HP arithmetic live in `enemy_life`.

## Test plan
- **Spawn delay:** reset, `ID` = 1, `SPAWN_FRAMES` = 30, enable high → `Respawn_Pulse` and `is_alive` rise on the cycle after the 60th tick; `Enemy_HP` = 4.
- **Single hit:** in ALIVE, `Bullet_Hit` with damage 1 → HP 3 and `Enemy_Is_Attacked` high next cycle; it stays high through exactly one tick. Hits during the next 7 ticks leave HP at 3; ALIVE resumes after the 7th tick.
- **Kill and respawn:** HP 2, damage 5 → HP 0 (saturated), `Kill_Pulse` for one cycle, `is_alive` 0, `Dying` 1 for 16 ticks, then DEAD for 120 ticks, then `Respawn_Pulse` with HP 4.
- **Hit coincident with tick:** `Bullet_Hit` and `game_frame_clk_rising_edge` in the same cycle → `Enemy_Is_Attacked` still high at the following tick; the HURT exit comes 7 ticks after that.
- **Freeze:** `Game_Enable` low for 50 ticks in DEAD → no progress and hits ignored; after re-enabling, the remaining tick count completes unchanged.
- **Async reset mid-DYING:** assert `Reset_n` low between clock edges → outputs clear immediately; state returns to SPAWN_WAIT with HP 0.

Source files
------------

// File: rtl/enemy_life_pkg.sv
// enemy_life_pkg: shared life-cycle state type, field widths and HP arithmetic.
package enemy_life_pkg;
   localparam int HP_W = 4;
   localparam int FC_W = 8;
   typedef enum logic [2:0] {SPAWN_WAIT, ALIVE, HURT, DYING, DEAD} life_state_t;
   function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp, input logic [HP_W-1:0] dmg);
      logic [HP_W:0] d;
      d = {1'b0, hp} - {1'b0, dmg};
      return d[HP_W] ? '0 : d[HP_W-1:0];
   endfunction
endpackage

// File: rtl/enemy_life_if.sv
// enemy_life_if: hit/tick inputs and life status outputs between game logic and enemy_life.
interface enemy_life_if;
   import enemy_life_pkg::*;
   logic            game_frame_clk_rising_edge;
   logic            Game_Enable;
   logic            Bullet_Hit;
   logic [HP_W-1:0] Bullet_Damage;
   logic            is_alive;
   logic            Enemy_Is_Attacked;
   logic [HP_W-1:0] Enemy_HP;
   logic            Dying;
   logic            Kill_Pulse;
   logic            Respawn_Pulse;
   modport master(
      output game_frame_clk_rising_edge, Game_Enable, Bullet_Hit, Bullet_Damage,
      input  is_alive, Enemy_Is_Attacked, Enemy_HP, Dying, Kill_Pulse, Respawn_Pulse
   );
   modport slave(
      input  game_frame_clk_rising_edge, Game_Enable, Bullet_Hit, Bullet_Damage,
      output is_alive, Enemy_Is_Attacked, Enemy_HP, Dying, Kill_Pulse, Respawn_Pulse
   );
endinterface

// File: rtl/enemy_life_frame_timer.sv
// enemy_life_frame_timer: loadable frame-tick down-counter; o_done marks the tick that ends the count.
module enemy_life_frame_timer
   import enemy_life_pkg::*;
#(
   parameter logic [FC_W-1:0] RST_VAL = '0
)(
   input  logic            Clk,
   input  logic            Reset_n,
   input  logic            i_tick,
   input  logic            i_load,
   input  logic [FC_W-1:0] i_load_val,
   output logic            o_done
);
   logic [FC_W-1:0] r_cnt;
   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) r_cnt <= RST_VAL;
      else if (i_load) r_cnt <= i_load_val;
      else if (i_tick && r_cnt != '0) r_cnt <= r_cnt - FC_W'(1);
   assign o_done = i_tick && r_cnt == FC_W'(1);
endmodule

// File: rtl/enemy_life.sv
// enemy_life: per-enemy spawn/hit/death/respawn controller feeding the enemy sprite logic.
module enemy_life
   import enemy_life_pkg::*;
#(
   parameter int ID             = 0,
   parameter int MAX_HP         = 4,
   parameter int HIT_FRAMES     = 7,
   parameter int DEATH_FRAMES   = 16,
   parameter int RESPAWN_FRAMES = 120,
   parameter int SPAWN_FRAMES   = 30
)(
   input logic         Clk,
   input logic         Reset_n,
   enemy_life_if.slave life
);
   localparam logic [FC_W-1:0] SPAWN_TICKS = FC_W'(SPAWN_FRAMES * (ID + 1));
   life_state_t     r_state, w_state;
   logic [HP_W-1:0] r_hp, w_hp, w_hit_hp;
   logic            r_att, w_att, r_kill, w_kill, r_resp, w_resp;
   logic            w_tick, w_hit, w_load, w_done;
   logic [FC_W-1:0] w_load_val;
   assign w_tick   = life.game_frame_clk_rising_edge & life.Game_Enable;
   assign w_hit    = life.Bullet_Hit & life.Game_Enable;
   assign w_hit_hp = sat_sub(r_hp, life.Bullet_Damage);
   enemy_life_frame_timer #(.RST_VAL(SPAWN_TICKS)) u_frame_timer (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .i_tick     (w_tick),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_done     (w_done)
   );
   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) begin
         r_state <= SPAWN_WAIT;
         r_hp    <= '0;
         r_att   <= 1'b0;
         r_kill  <= 1'b0;
         r_resp  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_hp    <= w_hp;
         r_att   <= w_att;
         r_kill  <= w_kill;
         r_resp  <= w_resp;
      end
   // The attacked level drops after the first enabled tick; a hit on a tick re-arms it and wins.
   always_comb begin
      w_state    = r_state;
      w_hp       = r_hp;
      w_att      = r_att & ~w_tick;
      w_kill     = 1'b0;
      w_resp     = 1'b0;
      w_load     = 1'b0;
      w_load_val = '0;
      case (r_state)
         SPAWN_WAIT, DEAD: if (w_done) begin
            w_state = ALIVE;
            w_hp    = HP_W'(MAX_HP);
            w_resp  = 1'b1;
         end
         ALIVE: if (w_hit) begin
            w_hp       = w_hit_hp;
            w_kill     = w_hit_hp == '0;
            w_att      = !w_kill;
            w_state    = w_kill ? DYING : HURT;
            w_load     = 1'b1;
            w_load_val = w_kill ? FC_W'(DEATH_FRAMES) : FC_W'(HIT_FRAMES);
         end
         HURT: if (w_done) w_state = ALIVE;
         DYING: if (w_done) begin
            w_state    = DEAD;
            w_load     = 1'b1;
            w_load_val = FC_W'(RESPAWN_FRAMES);
         end
         default: w_state = SPAWN_WAIT;
      endcase
   end
   assign life.is_alive          = r_state == ALIVE || r_state == HURT;
   assign life.Dying             = r_state == DYING;
   assign life.Enemy_HP          = r_hp;
   assign life.Enemy_Is_Attacked = r_att;
   assign life.Kill_Pulse        = r_kill;
   assign life.Respawn_Pulse     = r_resp;
endmodule
